// File: rtl/imm_ext_pipe_pkg.sv
// imm_ext_pipe_pkg
//   Shared definitions for the immediate-extension pipeline stage:
//   default widths and the 2-bit mode encoding presented by decode.
package imm_ext_pipe_pkg;

  localparam int IMMWIDTH_DEF  = 8;
  localparam int DATAWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IMM_SEXT   = 2'b00,
    IMM_ZEXT   = 2'b01,
    IMM_UPPER  = 2'b10,
    IMM_PREFIX = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_pipe_extend.sv
// imm_extend
//   Combinational widening of an instruction immediate; successor to the
//   plain sign extender. PREFIX mode produces zero here because prefixes
//   never reach the output register directly.
// Ports:
//   imm   in  IMMWIDTH   raw immediate field
//   mode  in  2          SEXT / ZEXT / UPPER / PREFIX
//   ext   out DATAWIDTH  widened value
module imm_extend
  import imm_ext_pipe_pkg::*;
#(
  parameter int IMMWIDTH  = IMMWIDTH_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [IMMWIDTH-1:0]  imm,
  input  logic [1:0]           mode,
  output logic [DATAWIDTH-1:0] ext
);

  localparam int PW = DATAWIDTH - IMMWIDTH;

  always_comb begin
    ext = '0;
    case (imm_mode_e'(mode))
      IMM_SEXT:  ext = {{PW{imm[IMMWIDTH-1]}}, imm};
      IMM_ZEXT:  ext = {{PW{1'b0}}, imm};
      // Only the low PW bits of the immediate fit above the IMMWIDTH zeros.
      IMM_UPPER: ext = {imm[PW-1:0], {IMMWIDTH{1'b0}}};
      default:   ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
//   Registered immediate extender between decode and the ALU operand mux.
//   Holds a one-deep output register and an optional prefix so that a
//   PREFIX instruction followed by any non-prefix instruction builds a
//   full-width constant {pfx, imm}.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   flush        in   drop held output and pending prefix
//   valid_in     in   decode presents an immediate
//   ready_in     out  stage can accept this cycle
//   imm          in   IMMWIDTH raw immediate
//   mode         in   2-bit mode (imm_mode_e)
//   valid_out    out  imm_ext holds a result
//   ready_out    in   ALU consumes the result
//   imm_ext      out  DATAWIDTH registered result
//   pfx_pending  out  prefix stored and not yet consumed
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IMMWIDTH  = IMMWIDTH_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [IMMWIDTH-1:0]  imm,
  input  logic [1:0]           mode,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [DATAWIDTH-1:0] imm_ext,
  output logic                 pfx_pending
);

  localparam int PW = DATAWIDTH - IMMWIDTH;

  logic                 valid_out_q,   valid_out_d;
  logic [DATAWIDTH-1:0] imm_ext_q,     imm_ext_d;
  logic                 pfx_pending_q, pfx_pending_d;
  logic [PW-1:0]        pfx_reg_q,     pfx_reg_d;

  logic [DATAWIDTH-1:0] ext_val;
  logic                 accept;

  imm_extend #(
    .IMMWIDTH  (IMMWIDTH),
    .DATAWIDTH (DATAWIDTH)
  ) u_extend (
    .imm  (imm),
    .mode (mode),
    .ext  (ext_val)
  );

  // Uniform across modes and independent of flush, so a stall also
  // refuses PREFIX inputs.
  assign ready_in = !valid_out_q || ready_out;
  assign accept   = valid_in && ready_in && !flush;

  always_comb begin
    valid_out_d   = valid_out_q;
    imm_ext_d     = imm_ext_q;
    pfx_pending_d = pfx_pending_q;
    pfx_reg_d     = pfx_reg_q;

    // Drain first; a same-cycle accept below reloads with no bubble.
    if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
    end

    if (flush) begin
      valid_out_d   = 1'b0;
      pfx_pending_d = 1'b0;
    end else if (accept) begin
      if (mode == IMM_PREFIX) begin
        pfx_reg_d     = imm[PW-1:0];
        pfx_pending_d = 1'b1;
      end else begin
        // A pending prefix overrides the requested mode.
        imm_ext_d     = pfx_pending_q ? {pfx_reg_q, imm} : ext_val;
        valid_out_d   = 1'b1;
        pfx_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_q   <= 1'b0;
      imm_ext_q     <= '0;
      pfx_pending_q <= 1'b0;
      pfx_reg_q     <= '0;
    end else begin
      valid_out_q   <= valid_out_d;
      imm_ext_q     <= imm_ext_d;
      pfx_pending_q <= pfx_pending_d;
      pfx_reg_q     <= pfx_reg_d;
    end
  end

  assign valid_out   = valid_out_q;
  assign imm_ext     = imm_ext_q;
  assign pfx_pending = pfx_pending_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, ready_out;
  logic        ready_in, valid_out, pfx_pending;
  logic [7:0]  imm;
  logic [1:0]  mode;
  logic [15:0] imm_ext;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IMMWIDTH(8), .DATAWIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .imm         (imm),
    .mode        (mode),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .imm_ext     (imm_ext),
    .pfx_pending (pfx_pending)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  imm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d);
    valid_in = v;
    mode     = m;
    imm      = d;
  endtask

  // Reference widening by plain arithmetic.
  function automatic logic [15:0] ref_ext(input logic [1:0] m, input logic [7:0] v);
    int x;
    x = int'(v);
    case (m)
      2'd0:    return 16'((x >= 128) ? x + 65280 : x);
      2'd1:    return 16'(x);
      default: return 16'(x * 256);
    endcase
  endfunction

  // Behavioural model state for the random phase.
  bit          m_valid, m_pend;
  logic [15:0] m_val;
  logic [7:0]  m_pfx;

  initial begin
    vecs[0] = '{2'd0, 8'h80, 16'hFF80};
    vecs[1] = '{2'd1, 8'h80, 16'h0080};
    vecs[2] = '{2'd2, 8'h80, 16'h8000};
    vecs[3] = '{2'd0, 8'h7F, 16'h007F};
    vecs[4] = '{2'd0, 8'hFF, 16'hFFFF};
    vecs[5] = '{2'd1, 8'hFF, 16'h00FF};
    vecs[6] = '{2'd2, 8'h01, 16'h0100};
    vecs[7] = '{2'd2, 8'hFF, 16'hFF00};

    reset = 1'b1; flush = 1'b0; ready_out = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    tick(); tick();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_imm_ext", 32'(imm_ext), 32'd0);
    check("rst_pfx_pending", 32'(pfx_pending), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    reset = 1'b0;
    tick();

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm);
      tick();
      check("vec_valid", 32'(valid_out), 32'd1);
      check("vec_imm_ext", 32'(imm_ext), 32'(vecs[i].exp));
    end

    // Exhaustive modes, back-to-back with ready_out high
    for (int m = 0; m < 3; m++) begin
      for (int v = 0; v < 256; v++) begin
        drive(1'b1, 2'(m), 8'(v));
        tick();
        check("exh_imm_ext", 32'(imm_ext), 32'(ref_ext(2'(m), 8'(v))));
      end
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    check("drain_valid", 32'(valid_out), 32'd0);

    // Prefix pairing
    drive(1'b1, 2'd3, 8'h12);
    tick();
    check("pair_pend", 32'(pfx_pending), 32'd1);
    check("pair_no_out", 32'(valid_out), 32'd0);
    drive(1'b1, 2'd2, 8'h34);
    tick();
    check("pair_imm_ext", 32'(imm_ext), 32'h1234);
    check("pair_valid", 32'(valid_out), 32'd1);
    check("pair_pend_clr", 32'(pfx_pending), 32'd0);
    drive(1'b0, 2'd0, 8'h00);
    tick();

    // Prefix overwrite
    drive(1'b1, 2'd3, 8'hAA);
    tick();
    check("ovw_no_out1", 32'(valid_out), 32'd0);
    drive(1'b1, 2'd3, 8'h55);
    tick();
    check("ovw_no_out2", 32'(valid_out), 32'd0);
    check("ovw_pend", 32'(pfx_pending), 32'd1);
    drive(1'b1, 2'd1, 8'hF0);
    tick();
    check("ovw_imm_ext", 32'(imm_ext), 32'h55F0);

    // Backpressure
    drive(1'b1, 2'd0, 8'hFE);
    tick();
    check("bp_first", 32'(imm_ext), 32'hFFFE);
    ready_out = 1'b0;
    drive(1'b1, 2'd1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready_in", 32'(ready_in), 32'd0);
      tick();
      check("bp_hold", 32'(imm_ext), 32'hFFFE);
      check("bp_valid", 32'(valid_out), 32'd1);
    end
    ready_out = 1'b1;
    #1;
    check("bp_release_ready", 32'(ready_in), 32'd1);
    tick();
    check("bp_next", 32'(imm_ext), 32'h0001);
    check("bp_next_valid", 32'(valid_out), 32'd1);
    drive(1'b0, 2'd0, 8'h00);
    tick();

    // Flush
    drive(1'b1, 2'd3, 8'h7F);
    tick();
    flush = 1'b1;
    drive(1'b1, 2'd0, 8'h01);
    tick();
    check("fl_pend", 32'(pfx_pending), 32'd0);
    check("fl_valid", 32'(valid_out), 32'd0);
    flush = 1'b0;
    tick();
    check("fl_after", 32'(imm_ext), 32'h0001);

    // Reset mid-stall
    ready_out = 1'b0;
    drive(1'b1, 2'd1, 8'h22);
    tick(); tick();
    check("rs_stalled", 32'(valid_out), 32'd1);
    drive(1'b0, 2'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_valid", 32'(valid_out), 32'd0);
    check("rs_imm_ext", 32'(imm_ext), 32'd0);
    check("rs_ready_in", 32'(ready_in), 32'd1);

    // Reset with a prefix pending
    drive(1'b1, 2'd3, 8'h44);
    tick();
    check("rp_pend_set", 32'(pfx_pending), 32'd1);
    drive(1'b0, 2'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rp_pend", 32'(pfx_pending), 32'd0);
    check("rp_ready_in", 32'(ready_in), 32'd1);
    ready_out = 1'b1;
    drive(1'b1, 2'd0, 8'h05);
    tick();
    check("rp_unprefixed", 32'(imm_ext), 32'h0005);

    // Randomized phase against the model; start from a known reset.
    drive(1'b0, 2'd0, 8'h00);
    reset = 1'b1;
    tick();
    m_valid = 0; m_pend = 0; m_val = '0; m_pfx = '0;
    for (int c = 0; c < 3000; c++) begin
      bit m_ready;
      reset     = ($urandom_range(63) == 0);
      flush     = ($urandom_range(15) == 0);
      ready_out = ($urandom_range(3) != 0);
      drive(1'(($urandom_range(3) != 0)), 2'($urandom_range(3)), 8'($urandom_range(255)));
      #1;
      m_ready = !m_valid || ready_out;
      check("rnd_ready_in", 32'(ready_in), 32'(m_ready));
      if (reset) begin
        m_valid = 0; m_pend = 0; m_val = '0; m_pfx = '0;
      end else begin
        if (m_valid && ready_out) m_valid = 0;
        if (flush) begin
          m_valid = 0;
          m_pend  = 0;
        end else if (valid_in && m_ready) begin
          if (mode == 2'd3) begin
            m_pfx  = imm;
            m_pend = 1;
          end else begin
            m_val   = m_pend ? 16'(int'(m_pfx) * 256 + int'(imm)) : ref_ext(mode, imm);
            m_valid = 1;
            m_pend  = 0;
          end
        end
      end
      tick();
      check("rnd_valid", 32'(valid_out), 32'(m_valid));
      check("rnd_pend", 32'(pfx_pending), 32'(m_pend));
      check("rnd_imm_ext", 32'(imm_ext), 32'(m_val));
      check("rnd_xfree", 32'($isunknown(imm_ext)), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Registered, parametrised successor to the combinational `signext` unit. It widens an IMMWIDTH-bit instruction immediate to DATAWIDTH bits in one of several modes, and holds an optional immediate prefix so two instructions can build a full-width constant. It sits between decode and the ALU operand mux, with a valid/ready handshake on both sides so a stalled execute stage backpressures decode.

## Interface
- `IMMWIDTH`, default 8: input immediate width; defaults from `IMMWIDTH in defines.v.
- `DATAWIDTH`, default 16: output width. Legal only when IMMWIDTH < DATAWIDTH ≤ 2·IMMWIDTH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `flush`  in  1  pipeline flush; drops the held output and any pending prefix.
- `valid_in`  in  1  decode presents an immediate.
- `ready_in`  out  1  unit can accept this cycle.
- `imm`  in  IMMWIDTH  raw immediate field.
- `mode`  in  2  00 SEXT, 01 ZEXT, 10 UPPER, 11 PREFIX.
- `valid_out`  out  1  `imm_ext` holds a result.
- `ready_out`  in  1  ALU stage consumes the result.
- `imm_ext`  out  DATAWIDTH  extended immediate (registered).
- `pfx_pending`  out  1  a prefix is stored and not yet consumed.

## Operation
- Define PW = DATAWIDTH − IMMWIDTH.
- Accept handshake: `valid_in && ready_in && !flush`.
- `ready_in = !valid_out || ready_out`. The output register is one deep, and a result can be replaced in the same cycle it drains.
- On an accept with mode ≠ PREFIX and `pfx_pending` = 0:
  - SEXT: `{PW{imm[IMMWIDTH-1]}}, imm`.
  - ZEXT: `{PW{1'b0}}, imm`.
  - UPPER: `imm[PW-1:0]` placed in the top PW bits, with the low IMMWIDTH bits zero.
  - In all three cases `valid_out` is set.
- On an accept with mode ≠ PREFIX and `pfx_pending` = 1:
  - Result is `{pfx_reg, imm}`; `mode` is ignored.
  - `pfx_pending` clears and `valid_out` is set.
- On an accept with mode = PREFIX:
  - `pfx_reg <= imm[PW-1:0]` and `pfx_pending <= 1`.
  - No output is produced and `valid_out`/`imm_ext` are unaffected by this accept.
  - A second PREFIX before consumption overwrites the first, and `pfx_pending` stays 1.
- If `valid_out && ready_out` with no new result accepted that cycle, `valid_out` clears and `imm_ext` holds its value.
- `flush` (dominates everything except `reset`):
  - Clears `valid_out` and `pfx_pending`.
  - Any simultaneous `valid_in` is dropped.
  - `ready_in` is still computed normally.
- `reset`: `valid_out`=0, `imm_ext`=0, `pfx_pending`=0, `pfx_reg`=0.
- `imm_ext` is X-free and stable while `valid_out && !ready_out`.

## Timing
- Latency is 1 cycle: data accepted at edge N is visible on `imm_ext`/`valid_out` after edge N.
- Throughput is 1 result per cycle while `ready_out` = 1.
- A prefix costs 1 accept cycle with no output, so a prefixed constant has 2-cycle latency from the PREFIX accept.
- Stall: while `valid_out && !ready_out`, `ready_in` = 0 and the output holds.
  - PREFIX inputs are also refused during a stall, because `ready_in` is uniform across modes.
- Simultaneous drain and accept: the old result leaves and the new one loads on the same edge, with no bubble.
- Reset asserted mid-stall or with a pending prefix: everything clears on that edge, and `ready_in` = 1 the following cycle.

## Structure
- Shared `defines.v` holds:
  - `IMMWIDTH, `DATAWIDTH;
  - mode codes `IMM_SEXT (2'b00), `IMM_ZEXT (2'b01), `IMM_UPPER (2'b10), `IMM_PREFIX (2'b11).
- One combinational sub-module, `imm_extend` (imm, mode → extended value), generalises the existing sign extender.
  - It is unit-tested exhaustively, like `signext`.
- The top level holds the output register, `pfx_reg`, `pfx_pending` and the handshake logic.

## Test plan
All scenarios use IMMWIDTH=8, DATAWIDTH=16.
- Exhaustive modes: every `imm` 0..255 in SEXT, ZEXT and UPPER with `ready_out`=1.
  - Expect `imm`=8'h80 → 16'hFF80 / 16'h0080 / 16'h8000, each one cycle after accept.
- Prefix pairing: PREFIX 8'h12, then SEXT 8'h34 → `imm_ext`=16'h1234.
  - `pfx_pending` is high for exactly one cycle, and mode is ignored on the consuming input.
- Prefix overwrite: PREFIX 8'hAA, PREFIX 8'h55, ZEXT 8'hF0 → 16'h55F0. No output appears for either PREFIX.
- Backpressure: SEXT 8'hFE accepted while `ready_out`=0 for 3 cycles.
  - `imm_ext` holds 16'hFFFE and `ready_in`=0 throughout.
  - Then `ready_out`=1 with a new ZEXT 8'h01 → next cycle 16'h0001, with no bubble.
- Flush: PREFIX 8'h7F, then `flush` concurrent with `valid_in` SEXT 8'h01.
  - Input dropped, `pfx_pending`=0, `valid_out`=0.
  - Next SEXT 8'h01 → 16'h0001, not 16'h7F01.
- Reset mid-stall: with `valid_out`=1, `ready_out`=0 and a prefix pending, assert `reset` for 1 cycle.
  - All outputs are 0 and `ready_in`=1 on the next cycle.
